mem_wb_pipe: RTL and testbench

//  Parametrised MEM->WB pipeline register with valid/ready flow control, a 2-entry skid buffer
//  and a synchronous flush. Sits between the data-memory stage and the register-file write port.

---
 rtl/mips_pkg.sv | 12 +
 rtl/skid_slot.sv | 33 +++
 rtl/mem_wb_pipe.sv | 105 ++++++++++
 tb/tb_mem_wb_pipe.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared writeback-control bit indices and default widths
package mips_pkg;

    localparam int WB_REGWRITE     = 1;
    localparam int WB_MEMTOREG     = 0;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_REG_ADDR_W  = 5;
    localparam int DEF_WB_W        = 2;
    localparam int DEF_STALL_CNT_W = 16;

endpackage

// File: rtl/skid_slot.sv
// rtl/skid_slot.sv - one valid flag plus payload register with load and clear
module skid_slot #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 clear,
    input  logic [PAYLOAD_W-1:0] d,
    output logic                 valid,
    output logic [PAYLOAD_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // Clear wins over load, and a squashed load must not disturb the stale payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load && !clear) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - MEM->WB pipeline register with 2-entry skid, flush, forwarding and stall counter
module mem_wb_pipe
    import mips_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int WB_W        = DEF_WB_W,
    parameter int STALL_CNT_W = DEF_STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WB_W-1:0]        in_wb,
    input  logic [DATA_W-1:0]      in_mem_rdata,
    input  logic [DATA_W-1:0]      in_alu_res,
    input  logic [REG_ADDR_W-1:0]  in_rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WB_W-1:0]        out_wb,
    output logic [REG_ADDR_W-1:0]  out_rd,
    output logic [DATA_W-1:0]      wb_data,
    output logic                   wb_we,
    output logic                   fwd_valid,
    output logic [REG_ADDR_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0]      fwd_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int PW = WB_W + 2 * DATA_W + REG_ADDR_W;

    logic          head_valid, skid_valid;
    logic          head_load, head_clear, skid_load, skid_clear;
    logic [PW-1:0] in_payload, head_payload, skid_payload, head_d;
    logic [DATA_W-1:0] head_mem, head_alu;
    logic          accept, drain, rd_live;

    assign in_payload = {in_wb, in_mem_rdata, in_alu_res, in_rd};
    assign in_ready   = !skid_valid;
    assign accept     = in_valid && in_ready;
    assign drain      = head_valid && out_ready;

    always_comb begin
        head_load  = 1'b0;
        head_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        head_d     = skid_valid ? skid_payload : in_payload;
        if (flush) begin
            head_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (!skid_valid) begin
            if (!head_valid || drain) begin
                head_load  = accept;
                head_clear = !accept && drain;
            end else begin
                skid_load = accept;
            end
        end else if (drain) begin
            // Skid refills the head; input is blocked this cycle because in_ready is low.
            head_load  = 1'b1;
            skid_clear = 1'b1;
        end
    end

    skid_slot #(.PAYLOAD_W(PW)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (head_load),
        .clear (head_clear),
        .d     (head_d),
        .valid (head_valid),
        .q     (head_payload)
    );

    skid_slot #(.PAYLOAD_W(PW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_payload),
        .valid (skid_valid),
        .q     (skid_payload)
    );

    assign {out_wb, head_mem, head_alu, out_rd} = head_payload;

    assign out_valid = head_valid;
    assign wb_data   = out_wb[WB_MEMTOREG] ? head_mem : head_alu;
    assign rd_live   = head_valid && out_wb[WB_REGWRITE] && (out_rd != '0);
    assign wb_we     = rd_live && out_ready;
    assign fwd_valid = rd_live;
    assign fwd_rd    = out_rd;
    assign fwd_data  = wb_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (head_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - directed and randomized checks of mem_wb_pipe against a queue model
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_wb = '0;
    logic [31:0] in_mem_rdata = '0;
    logic [31:0] in_alu_res = '0;
    logic [4:0]  in_rd = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, wb_we, fwd_valid;
    logic [1:0]  out_wb;
    logic [4:0]  out_rd, fwd_rd;
    logic [31:0] wb_data, fwd_data;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid, s_wb_we, s_fwd_valid;
    logic [1:0]  s_out_wb;
    logic [4:0]  s_out_rd, s_fwd_rd;
    logic [31:0] s_wb_data, s_fwd_data;
    logic [1:0]  s_stall_cnt;

    always #5 clk = ~clk;

    mem_wb_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_wb(in_wb),
        .in_mem_rdata(in_mem_rdata), .in_alu_res(in_alu_res), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_wb(out_wb), .out_rd(out_rd),
        .wb_data(wb_data), .wb_we(wb_we), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .stall_cnt(stall_cnt)
    );

    mem_wb_pipe #(.STALL_CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_wb(in_wb),
        .in_mem_rdata(in_mem_rdata), .in_alu_res(in_alu_res), .in_rd(in_rd),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_wb(s_out_wb), .out_rd(s_out_rd),
        .wb_data(s_wb_data), .wb_we(s_wb_we), .fwd_valid(s_fwd_valid), .fwd_rd(s_fwd_rd),
        .fwd_data(s_fwd_data), .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  rd;
    } ent_t;

    ent_t q[$];
    int   stall16 = 0;
    int   stall2 = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        ent_t  h;
        logic  v, live;
        logic [31:0] exp_data;
        v = (q.size() > 0);
        live = 1'b0;
        exp_data = '0;
        chk("out_valid", out_valid, v);
        chk("in_ready", in_ready, q.size() < 2);
        chk("sat_out_valid", s_out_valid, v);
        chk("sat_in_ready", s_in_ready, q.size() < 2);
        if (v) begin
            h = q[0];
            live = h.wb[1] && (h.rd != 0);
            exp_data = h.wb[0] ? h.mem : h.alu;
            chk("out_wb", out_wb, h.wb);
            chk("out_rd", out_rd, h.rd);
            chk("wb_data", wb_data, exp_data);
            chk("fwd_rd", fwd_rd, h.rd);
            chk("fwd_data", fwd_data, exp_data);
            chk("sat_wb_data", s_wb_data, exp_data);
            chk("sat_out_rd", s_out_rd, h.rd);
            chk("sat_out_wb", s_out_wb, h.wb);
            chk("sat_fwd", {s_fwd_rd, s_fwd_data}, {h.rd, exp_data});
        end
        chk("fwd_valid", fwd_valid, live);
        chk("wb_we", wb_we, live && out_ready);
        chk("sat_we_fwd", {s_wb_we, s_fwd_valid}, {live && out_ready, live});
        chk("stall_cnt", stall_cnt, stall16);
        chk("sat_stall_cnt", s_stall_cnt, stall2);
    endtask

    task automatic cyc(input logic iv, input logic [1:0] w, input logic [31:0] m,
                       input logic [31:0] a, input logic [4:0] r, input logic ordy,
                       input logic fl);
        ent_t e;
        logic acc, drn;
        @(negedge clk);
        in_valid = iv; in_wb = w; in_mem_rdata = m; in_alu_res = a; in_rd = r;
        out_ready = ordy; flush = fl;
        #1;
        check_model();
        acc = iv && (q.size() < 2);
        drn = (q.size() > 0) && ordy;
        if ((q.size() > 0) && !ordy) begin
            if (stall16 < 65535) stall16++;
            if (stall2 < 3) stall2++;
        end
        e.wb = w; e.mem = m; e.alu = a; e.rd = r;
        if (fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_stall_cnt", stall_cnt, 16'd0);
        chk("rst_sat_stall", s_stall_cnt, 2'd0);
        q.delete();
        stall16 = 0;
        stall2 = 0;
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] rr;
        repeat (2) @(negedge clk);
        #1;
        chk("init_out_valid", out_valid, 1'b0);
        chk("init_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        // Reset mid-stream with head and skid both occupied
        cyc(1'b1, 2'b10, 32'h0, 32'h111, 5'd1, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 32'h0, 32'h222, 5'd2, 1'b0, 1'b0);
        #2;
        chk("t1_full", {out_valid, in_ready}, 2'b10);
        do_reset();

        // Back-pressure: A to head, B to skid, C held until room
        cyc(1'b1, 2'b10, 32'h0, 32'hA, 5'd10, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 32'h0, 32'hB, 5'd11, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 32'h0, 32'hC, 5'd12, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 32'h0, 32'hC, 5'd12, 1'b1, 1'b0);
        #2;
        chk("t3_second_out", wb_data, 32'hB);
        cyc(1'b1, 2'b10, 32'h0, 32'hC, 5'd12, 1'b1, 1'b0);
        #2;
        chk("t3_third_out", wb_data, 32'hC);
        cyc(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
        #2;
        chk("t3_stall_cnt", stall_cnt, 16'd2);
        chk("t3_empty", out_valid, 1'b0);

        // Streaming single entry
        cyc(1'b1, 2'b10, 32'h0, 32'h10, 5'd5, 1'b1, 1'b0);
        #2;
        chk("t2_out_rd", out_rd, 5'd5);
        chk("t2_wb_data", wb_data, 32'h10);
        chk("t2_wb_we", wb_we, 1'b1);

        // MemToReg select, then the same to r0
        cyc(1'b1, 2'b11, 32'hDEADBEEF, 32'h4, 5'd7, 1'b1, 1'b0);
        #2;
        chk("t4_memtoreg", wb_data, 32'hDEADBEEF);
        chk("t4_we", wb_we, 1'b1);
        cyc(1'b1, 2'b11, 32'hDEADBEEF, 32'h4, 5'd0, 1'b1, 1'b0);
        #2;
        chk("t4_r0_data", wb_data, 32'hDEADBEEF);
        chk("t4_r0_we", {wb_we, fwd_valid}, 2'b00);
        cyc(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);

        // Flush with head and skid full and a new entry offered
        cyc(1'b1, 2'b10, 32'h0, 32'h51, 5'd3, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 32'h0, 32'h52, 5'd4, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 32'h0, 32'h53, 5'd6, 1'b0, 1'b1);
        #2;
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_in_ready", in_ready, 1'b1);
        chk("t5_no_write", wb_we, 1'b0);
        cyc(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);

        // Saturation of the narrow counter
        do_reset();
        cyc(1'b1, 2'b10, 32'h0, 32'h77, 5'd9, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        #2;
        chk("t6_sat_stall", s_stall_cnt, 2'd3);
        chk("t6_wide_stall", stall_cnt, 16'd5);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cyc($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom, $urandom, rr,
                $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end
        cyc(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
